bcd_time_counter: RTL and testbench
===================================

BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

Interface
REQ-001 SHALL have parameter p_CLKS_PER_SEC, default 50000000: i_Clock cycles per second tick; legal range >=1, where 1 gives a tick every enabled cycle.
REQ-002 SHALL have parameter p_MODE_12H, default 0: 0 gives a 24-hour clock (00..23); 1 gives a 12-hour clock (12,01..11) plus an AM/PM flag.
REQ-003 SHALL have i_Clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have i_Reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have i_Run  input  1  1 = timekeeping enabled.
REQ-006 SHALL have i_Set_Sel  input  2  0 = run mode, 1 = set seconds, 2 = set minutes, 3 = set hours.
REQ-007 SHALL have i_Inc  input  1  single-cycle pulse; adds 1 to the selected field.
REQ-008 SHALL have i_Dec  input  1  single-cycle pulse; subtracts 1 from the selected field.
REQ-009 SHALL have o_Units_Sec 4, o_Tens_Sec 3, o_Units_Min 4, o_Tens_Min 3, o_Units_Hour 4, o_Tens_Hour 2, all outputs holding BCD digits.
REQ-010 SHALL have o_PM  output  1  1 = PM; constant 0 when p_MODE_12H=0.
REQ-011 SHALL have o_Tick  output  1  one-cycle pulse marking each time advance in run mode.
REQ-012 SHALL have o_Day_Carry  output  1  one-cycle pulse at day rollover.

Function
REQ-013 Prescaler SHALL be $clog2(p_CLKS_PER_SEC) bits wide (min 1) and count 0..p_CLKS_PER_SEC-1 only while i_Run=1 and i_Set_Sel=0.
REQ-014 Prescaler terminal value SHALL produce an internal tick and wrap the prescaler to 0 on the same edge.
REQ-015 Prescaler SHALL hold its value while i_Run=0 (pause/resume mid-second) and SHALL clear to 0 and stay at 0 while i_Set_Sel!=0.
REQ-016 On tick, seconds SHALL advance 00..59; a 59->00 wrap SHALL advance minutes 00..59; a minute 59->00 wrap SHALL advance hours.
REQ-017 All digit and flag outputs SHALL be registered; the new time value SHALL appear on the edge after the tick cycle, with o_Tick=1 for exactly that one cycle.
REQ-018 24h mode: 23:59:59 -> 00:00:00, with o_Day_Carry=1 in the same cycle as o_Tick.
REQ-019 12h mode hours: 12 -> 01 with no PM change; 11:59:59 -> 12:00:00 SHALL toggle o_PM.
REQ-020 12h mode: a PM toggle from 1 to 0 SHALL pulse o_Day_Carry.
REQ-021 Set mode: i_Inc or i_Dec SHALL modify only the selected field by 1, wrapping within that field with no carry or borrow into other fields; the result SHALL be visible on the next edge.
REQ-022 Set wrap points: sec/min 59<->00; 24h hours 23<->00; 12h hours 12->01 on inc and 01->12 on dec.
REQ-023 12h set of hours: inc 11->12 and dec 12->11 SHALL toggle o_PM.
REQ-024 i_Inc=i_Dec=1 in the same cycle SHALL leave state unchanged.
REQ-025 i_Inc and i_Dec SHALL be ignored when i_Set_Sel=0.
REQ-026 o_Tick and o_Day_Carry SHALL never assert while i_Set_Sel!=0.
REQ-027 Digit invariants: tens sec/min <=5, units <=9, hours in the legal set for the mode; no other state is reachable.
REQ-028 Changing i_Set_Sel mid-count SHALL only hold and clear the prescaler; the time value SHALL be preserved.

Reset
REQ-029 i_Reset=1 SHALL override all other inputs on the same edge.
REQ-030 Reset state, 24h: time 00:00:00, o_PM=0.
REQ-031 Reset state, 12h: time 12:00:00 with o_PM=0 (AM).
REQ-032 Reset SHALL clear the prescaler, o_Tick and o_Day_Carry to 0.
REQ-033 Reset asserted mid-second or during set mode SHALL produce the same reset state; counting SHALL resume one full second after release when i_Run=1.

Verification (p_CLKS_PER_SEC=4)
REQ-034 Reset, then i_Run=1 for 8 cycles -> o_Tick pulses twice, 4 cycles apart; time reads 00:00:02.
REQ-035 24h, time preset via set mode to 23:59:59, then run 4 cycles -> 00:00:00 with o_Tick=1 and o_Day_Carry=1 in the same single cycle.
REQ-036 12h, 11:59:59 with o_PM=1, then run -> 12:00:00, o_PM=0, o_Day_Carry=1; next hour advance 12 -> 01 with o_PM unchanged.
REQ-037 Set minutes at 00 and pulse i_Dec -> minutes 59, hours and seconds unchanged; i_Inc and i_Dec together -> no change; i_Inc with i_Set_Sel=0 -> no change.
REQ-038 Run 2 cycles, i_Run=0 for 10 cycles, then i_Run=1 -> next o_Tick arrives 2 cycles after resume; i_Reset asserted concurrently with a tick -> reset state, no o_Tick.

Source files
------------

// File: rtl/bcd_time_counter.sv
// ----------------------------------------------------------------------------
// bcd_time_counter
//   Time-of-day counter with BCD digit outputs, run/pause control and a
//   field-at-a-time set mode. Hours run 00..23 (p_MODE_12H=0) or 12,01..11
//   with an AM/PM flag (p_MODE_12H=1).
//
// Parameters
//   p_CLKS_PER_SEC : i_Clock cycles per one-second advance (>=1)
//   p_MODE_12H     : 0 = 24-hour display, 1 = 12-hour display with o_PM
//
// Ports
//   i_Clock        : single clock, rising edge
//   i_Reset        : synchronous, active-high; overrides every other input
//   i_Run          : 1 = timekeeping enabled (prescaler holds while 0)
//   i_Set_Sel      : 0 run, 1 set seconds, 2 set minutes, 3 set hours
//   i_Inc / i_Dec  : single-cycle pulses adjusting the selected field
//   o_Units_Sec, o_Tens_Sec, o_Units_Min, o_Tens_Min,
//   o_Units_Hour, o_Tens_Hour : registered BCD digits
//   o_PM           : 1 = PM (12-hour mode only, otherwise constant 0)
//   o_Tick         : one-cycle pulse with each run-mode time advance
//   o_Day_Carry    : one-cycle pulse, coincident with o_Tick, at day rollover
// ----------------------------------------------------------------------------
module bcd_time_counter #(
  parameter int unsigned p_CLKS_PER_SEC = 50000000,
  parameter int unsigned p_MODE_12H     = 0
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Run,
  input  logic [1:0] i_Set_Sel,
  input  logic       i_Inc,
  input  logic       i_Dec,
  output logic [3:0] o_Units_Sec,
  output logic [2:0] o_Tens_Sec,
  output logic [3:0] o_Units_Min,
  output logic [2:0] o_Tens_Min,
  output logic [3:0] o_Units_Hour,
  output logic [1:0] o_Tens_Hour,
  output logic       o_PM,
  output logic       o_Tick,
  output logic       o_Day_Carry
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int unsigned LP_PW =
    (p_CLKS_PER_SEC > 1) ? $clog2(p_CLKS_PER_SEC) : 1;
  localparam logic [LP_PW-1:0] LP_TERM = LP_PW'(p_CLKS_PER_SEC - 1);

  localparam bit LP_12H = (p_MODE_12H != 0);

  // Hours are held as packed BCD {tens[1:0], units[3:0]}.
  localparam logic [5:0] LP_HOUR_HI  = LP_12H ? 6'h12 : 6'h23;
  localparam logic [5:0] LP_HOUR_LO  = LP_12H ? 6'h01 : 6'h00;
  localparam logic [5:0] LP_HOUR_RST = LP_12H ? 6'h12 : 6'h00;

  // Seconds and minutes are held as packed BCD {tens[2:0], units[3:0]}.
  localparam logic [6:0] LP_MS_MAX = 7'h59;

  typedef enum logic [1:0] {
    SEL_RUN  = 2'd0,
    SEL_SEC  = 2'd1,
    SEL_MIN  = 2'd2,
    SEL_HOUR = 2'd3
  } sel_e;

  // --------------------------------------------------------------------------
  // BCD field helpers
  // --------------------------------------------------------------------------
  function automatic logic [6:0] f_ms_inc(input logic [6:0] v);
    logic [6:0] r;
    if (v == LP_MS_MAX)        r = '0;
    else if (v[3:0] == 4'd9)   r = {v[6:4] + 3'd1, 4'd0};
    else                       r = {v[6:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [6:0] f_ms_dec(input logic [6:0] v);
    logic [6:0] r;
    if (v == 7'h00)            r = LP_MS_MAX;
    else if (v[3:0] == 4'd0)   r = {v[6:4] - 3'd1, 4'd9};
    else                       r = {v[6:4], v[3:0] - 4'd1};
    return r;
  endfunction

  function automatic logic [5:0] f_hour_inc(input logic [5:0] v);
    logic [5:0] r;
    if (v == LP_HOUR_HI)       r = LP_HOUR_LO;
    else if (v[3:0] == 4'd9)   r = {v[5:4] + 2'd1, 4'd0};
    else                       r = {v[5:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [5:0] f_hour_dec(input logic [5:0] v);
    logic [5:0] r;
    if (v == LP_HOUR_LO)       r = LP_HOUR_HI;
    else if (v[3:0] == 4'd0)   r = {v[5:4] - 2'd1, 4'd9};
    else                       r = {v[5:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [LP_PW-1:0] r_presc;
  logic [6:0]       r_sec;
  logic [6:0]       r_min;
  logic [5:0]       r_hour;
  logic             r_pm;
  logic             r_tick;
  logic             r_day_carry;

  sel_e             w_sel;
  logic             w_tick;
  logic             w_inc;
  logic             w_dec;
  logic [6:0]       w_sec_n;
  logic [6:0]       w_min_n;
  logic [5:0]       w_hour_n;
  logic             w_pm_n;
  logic             w_day_carry;

  assign w_sel  = sel_e'(i_Set_Sel);
  assign w_tick = i_Run && (w_sel == SEL_RUN) && (r_presc == LP_TERM);

  // Simultaneous inc and dec cancel out.
  assign w_inc  = i_Inc & ~i_Dec;
  assign w_dec  = i_Dec & ~i_Inc;

  // --------------------------------------------------------------------------
  // Next time value
  // --------------------------------------------------------------------------
  always_comb begin
    w_sec_n     = r_sec;
    w_min_n     = r_min;
    w_hour_n    = r_hour;
    w_pm_n      = r_pm;
    w_day_carry = 1'b0;

    case (w_sel)
      SEL_RUN: begin
        if (w_tick) begin
          w_sec_n = f_ms_inc(r_sec);
          if (r_sec == LP_MS_MAX) begin
            w_min_n = f_ms_inc(r_min);
            if (r_min == LP_MS_MAX) begin
              w_hour_n = f_hour_inc(r_hour);
              if (LP_12H) begin
                // 11 -> 12 flips AM/PM; leaving PM is the day boundary.
                if (r_hour == 6'h11) begin
                  w_pm_n      = ~r_pm;
                  w_day_carry = r_pm;
                end
              end else if (r_hour == 6'h23) begin
                w_day_carry = 1'b1;
              end
            end
          end
        end
      end

      SEL_SEC: begin
        if (w_inc)      w_sec_n = f_ms_inc(r_sec);
        else if (w_dec) w_sec_n = f_ms_dec(r_sec);
      end

      SEL_MIN: begin
        if (w_inc)      w_min_n = f_ms_inc(r_min);
        else if (w_dec) w_min_n = f_ms_dec(r_min);
      end

      SEL_HOUR: begin
        if (w_inc) begin
          w_hour_n = f_hour_inc(r_hour);
          if (LP_12H && (r_hour == 6'h11)) w_pm_n = ~r_pm;
        end else if (w_dec) begin
          w_hour_n = f_hour_dec(r_hour);
          if (LP_12H && (r_hour == 6'h12)) w_pm_n = ~r_pm;
        end
      end

      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_presc     <= '0;
      r_sec       <= '0;
      r_min       <= '0;
      r_hour      <= LP_HOUR_RST;
      r_pm        <= 1'b0;
      r_tick      <= 1'b0;
      r_day_carry <= 1'b0;
    end else begin
      // Set mode parks the prescaler at 0; pause holds it mid-second.
      if (w_sel != SEL_RUN) begin
        r_presc <= '0;
      end else if (i_Run) begin
        r_presc <= w_tick ? '0 : r_presc + LP_PW'(1);
      end

      r_sec       <= w_sec_n;
      r_min       <= w_min_n;
      r_hour      <= w_hour_n;
      r_pm        <= w_pm_n;
      r_tick      <= w_tick;
      r_day_carry <= w_day_carry;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_Units_Sec  = r_sec[3:0];
  assign o_Tens_Sec   = r_sec[6:4];
  assign o_Units_Min  = r_min[3:0];
  assign o_Tens_Min   = r_min[6:4];
  assign o_Units_Hour = r_hour[3:0];
  assign o_Tens_Hour  = r_hour[5:4];
  assign o_PM         = r_pm;
  assign o_Tick       = r_tick;
  assign o_Day_Carry  = r_day_carry;

endmodule

// File: tb/tb_bcd_time_counter.sv
// ----------------------------------------------------------------------------
// tb_bcd_time_counter
//   Drives a 24-hour and a 12-hour instance of bcd_time_counter from the same
//   stimulus and compares both against a seconds-of-day reference model.
// ----------------------------------------------------------------------------
module tb_bcd_time_counter;

  localparam int CPS = 4;
  localparam int DAY = 86400;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [1:0] sel;
  logic       inc;
  logic       dec;

  logic [3:0] us24, um24, uh24, us12, um12, uh12;
  logic [2:0] ts24, tm24, ts12, tm12;
  logic [1:0] th24, th12;
  logic       pm24, tick24, dc24, pm12, tick12, dc12;

  logic [19:0] obs24;
  logic [19:0] obs12;
  assign obs24 = {th24, uh24, tm24, um24, ts24, us24};
  assign obs12 = {th12, uh12, tm12, um12, ts12, us12};

  always #5 clk = ~clk;

  bcd_time_counter #(.p_CLKS_PER_SEC(CPS), .p_MODE_12H(0)) u_dut24 (
    .i_Clock(clk), .i_Reset(rst), .i_Run(run), .i_Set_Sel(sel),
    .i_Inc(inc), .i_Dec(dec),
    .o_Units_Sec(us24), .o_Tens_Sec(ts24), .o_Units_Min(um24),
    .o_Tens_Min(tm24), .o_Units_Hour(uh24), .o_Tens_Hour(th24),
    .o_PM(pm24), .o_Tick(tick24), .o_Day_Carry(dc24)
  );

  bcd_time_counter #(.p_CLKS_PER_SEC(CPS), .p_MODE_12H(1)) u_dut12 (
    .i_Clock(clk), .i_Reset(rst), .i_Run(run), .i_Set_Sel(sel),
    .i_Inc(inc), .i_Dec(dec),
    .o_Units_Sec(us12), .o_Tens_Sec(ts12), .o_Units_Min(um12),
    .o_Tens_Min(tm12), .o_Units_Hour(uh12), .o_Tens_Hour(th12),
    .o_PM(pm12), .o_Tick(tick12), .o_Day_Carry(dc12)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: time as seconds since midnight, plus a cycle counter.
  int m_t     = 0;
  int m_presc = 0;
  bit m_tick  = 0;
  bit m_dc    = 0;

  function automatic logic [19:0] pack_bcd(input int h, input int m,
                                           input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
            3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_set(input logic [1:0] f, input int d);
    int h, mi, s;
    h  = m_t / 3600;
    mi = (m_t / 60) % 60;
    s  = m_t % 60;
    case (f)
      2'd1: s  = (s + d + 60) % 60;
      2'd2: mi = (mi + d + 60) % 60;
      default: h = (h + d + 24) % 24;
    endcase
    m_t = h * 3600 + mi * 60 + s;
  endtask

  task automatic model_update(input logic a_rst, input logic a_run,
                              input logic [1:0] a_sel, input logic a_inc,
                              input logic a_dec);
    m_tick = 0;
    m_dc   = 0;
    if (a_rst) begin
      m_t     = 0;
      m_presc = 0;
    end else if (a_sel != 2'd0) begin
      m_presc = 0;
      if (a_inc && !a_dec)      model_set(a_sel, 1);
      else if (a_dec && !a_inc) model_set(a_sel, -1);
    end else if (a_run) begin
      if (m_presc == CPS - 1) begin
        m_presc = 0;
        m_tick  = 1;
        m_t     = m_t + 1;
        if (m_t == DAY) begin
          m_t  = 0;
          m_dc = 1;
        end
      end else begin
        m_presc++;
      end
    end
  endtask

  task automatic compare_all();
    int h24, h12, mi, s;
    bit pm;
    h24 = m_t / 3600;
    mi  = (m_t / 60) % 60;
    s   = m_t % 60;
    h12 = (h24 % 12 == 0) ? 12 : h24 % 12;
    pm  = (h24 >= 12);
    check_eq("time24", 32'(obs24), 32'(pack_bcd(h24, mi, s)));
    check_eq("time12", 32'(obs12), 32'(pack_bcd(h12, mi, s)));
    check_eq("pm12",   32'(pm12),   32'(pm));
    check_eq("pm24",   32'(pm24),   32'(0));
    check_eq("tick24", 32'(tick24), 32'(m_tick));
    check_eq("tick12", 32'(tick12), 32'(m_tick));
    check_eq("dc24",   32'(dc24),   32'(m_dc));
    check_eq("dc12",   32'(dc12),   32'(m_dc));
  endtask

  // One clock: drive inputs, advance model on the edge, sample 1 ns later.
  task automatic step(input logic a_rst, input logic a_run,
                      input logic [1:0] a_sel, input logic a_inc,
                      input logic a_dec);
    rst = a_rst; run = a_run; sel = a_sel; inc = a_inc; dec = a_dec;
    @(posedge clk);
    model_update(a_rst, a_run, a_sel, a_inc, a_dec);
    #1;
    compare_all();
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_ticks, first, last;
    rst = 1'b1; run = 1'b0; sel = 2'd0; inc = 1'b0; dec = 1'b0;
    @(negedge clk);

    // Reset state
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check_eq("rst_time24", 32'(obs24), 32'(pack_bcd(0, 0, 0)));
    check_eq("rst_time12", 32'(obs12), 32'(pack_bcd(12, 0, 0)));
    check_eq("rst_pm12",   32'(pm12),  32'(0));
    check_eq("rst_tick",   32'(tick24 | tick12 | dc24 | dc12), 32'(0));

    // Eight running cycles: two ticks, four apart
    n_ticks = 0; first = -1; last = -1;
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 0, 0);
      if (tick24) begin
        n_ticks++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check_eq("r34_ticks", 32'(n_ticks), 32'(2));
    check_eq("r34_gap",   32'(last - first), 32'(4));
    check_eq("r34_time",  32'(obs24), 32'(pack_bcd(0, 0, 2)));

    // Minute borrow-free wrap, inc+dec cancel, inc ignored in run mode
    step(0, 0, 2, 0, 1);
    check_eq("r37_dec_min", 32'(obs24), 32'(pack_bcd(0, 59, 2)));
    step(0, 0, 2, 1, 1);
    check_eq("r37_both",    32'(obs24), 32'(pack_bcd(0, 59, 2)));
    step(0, 0, 0, 1, 0);
    check_eq("r37_inc_run", 32'(obs24), 32'(pack_bcd(0, 59, 2)));

    // Preset 23:59:59 (11:59:59 PM) and roll over the day
    step(1, 0, 0, 0, 0);
    step(0, 0, 3, 0, 1);
    step(0, 0, 2, 0, 1);
    step(0, 0, 1, 0, 1);
    check_eq("r35_preset24", 32'(obs24), 32'(pack_bcd(23, 59, 59)));
    check_eq("r35_preset12", 32'(obs12), 32'(pack_bcd(11, 59, 59)));
    check_eq("r35_pm_set",   32'(pm12),  32'(1));
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, 0, 0);
      if (i < 4) check_eq("r35_early_tick", 32'(tick24 | dc24), 32'(0));
    end
    check_eq("r35_tick24", 32'(tick24), 32'(1));
    check_eq("r35_dc24",   32'(dc24),   32'(1));
    check_eq("r35_time24", 32'(obs24),  32'(pack_bcd(0, 0, 0)));
    check_eq("r36_dc12",   32'(dc12),   32'(1));
    check_eq("r36_time12", 32'(obs12),  32'(pack_bcd(12, 0, 0)));
    check_eq("r36_pm",     32'(pm12),   32'(0));

    // 12 -> 01 without PM change
    step(0, 1, 2, 0, 1);
    step(0, 1, 1, 0, 1);
    check_eq("r36_preset", 32'(obs12), 32'(pack_bcd(12, 59, 59)));
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 0, 0);
    check_eq("r36_hour1", 32'(obs12), 32'(pack_bcd(1, 0, 0)));
    check_eq("r36_pm1",   32'(pm12),  32'(0));
    check_eq("r36_nodc",  32'(dc12),  32'(0));

    // Pause mid-second, resume
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check_eq("r38_resume1", 32'(tick24), 32'(0));
    step(0, 1, 0, 0, 0);
    check_eq("r38_resume2", 32'(tick24), 32'(1));

    // Reset coinciding with a tick, then a full second before the next one
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check_eq("r38_rst_tick", 32'(tick24 | tick12), 32'(0));
    check_eq("r38_rst_time", 32'(obs24), 32'(pack_bcd(0, 0, 0)));
    n_ticks = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0);
      if (tick24) n_ticks++;
    end
    check_eq("r33_no_early", 32'(n_ticks), 32'(0));
    step(0, 1, 0, 0, 0);
    check_eq("r33_resume",   32'(tick24), 32'(1));

    // Reset during set mode
    step(0, 0, 3, 1, 0);
    step(1, 0, 3, 1, 0);
    check_eq("rst_set12", 32'(obs12), 32'(pack_bcd(12, 0, 0)));
    check_eq("rst_set24", 32'(obs24), 32'(pack_bcd(0, 0, 0)));

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic r_rst, r_run, r_inc, r_dec;
      logic [1:0] r_sel;
      r_rst = ($urandom_range(0, 299) == 0);
      r_run = ($urandom_range(0, 9) != 0);
      r_sel = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      r_inc = ($urandom_range(0, 2) == 0);
      r_dec = ($urandom_range(0, 2) == 0);
      step(r_rst, r_run, r_sel, r_inc, r_dec);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
